alu_md_ctrl: RTL and testbench



---
 rtl/alu_md_pkg.sv | 53 +++++
 rtl/md_iter_unit.sv | 106 ++++++++++
 rtl/alu_md_ctrl.sv | 112 +++++++++++
 tb/tb_alu_md_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
// Encodings shared by the ALU control decoder and the multiply/divide sequencer.
// The DIV state exists only when ALU_MD_DIV_EN is defined.
package alu_md_pkg;
    localparam logic [3:0] CMD_AND  = 4'b0000;
    localparam logic [3:0] CMD_OR   = 4'b0001;
    localparam logic [3:0] CMD_ADD  = 4'b0010;
    localparam logic [3:0] CMD_XOR  = 4'b0011;
    localparam logic [3:0] CMD_SUB  = 4'b0110;
    localparam logic [3:0] CMD_SLT  = 4'b0111;
    localparam logic [3:0] CMD_SLTU = 4'b1000;
    localparam logic [3:0] CMD_NOR  = 4'b1100;
    localparam logic [3:0] CMD_NOP  = 4'b1111;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_RTYPE = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_HI  = 2'b01;
    localparam logic [1:0] SEL_LO  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_MD_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_FIX  = 2'd3
    } md_state_t;
endpackage

// File: rtl/md_iter_unit.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, sign fixed in S_FIX.
// Result valid WIDTH+1 cycles after i_start; no backpressure, i_start ignored while busy.
module md_iter_unit
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    output logic             o_busy,
    output logic             o_res_vld,
    output logic [WIDTH-1:0] o_res_hi,
    output logic [WIDTH-1:0] o_res_lo
);
    md_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_neg_q, r_neg_r, r_div0, r_is_div;

    logic               w_rs_neg, w_rt_neg;
    logic [WIDTH-1:0]   w_rs_abs, w_rt_abs;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_nxt, w_prod;
    logic [WIDTH-1:0]   w_rem_fix, w_quo_fix;

    assign w_rs_neg = i_signed & i_rs[WIDTH-1];
    assign w_rt_neg = i_signed & i_rt[WIDTH-1];
    assign w_rs_abs = w_rs_neg ? -i_rs : i_rs;
    assign w_rt_abs = w_rt_neg ? -i_rt : i_rt;

    // acc = {partial product, remaining multiplier bits}; add into the top half, shift right
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

`ifdef ALU_MD_DIV_EN
    logic [WIDTH:0]     w_part;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_div_nxt;

    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    assign w_part    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = {1'b0, w_part} - {2'b00, r_opb};
    assign w_div_nxt = w_diff[WIDTH+1] ? {w_part[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                       : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
`endif

    // A zero divisor leaves quotient all ones and remainder = |rs|, so only the quotient negate is suppressed
    assign w_prod    = r_neg_q ? -r_acc : r_acc;
    assign w_rem_fix = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_quo_fix = (r_neg_q && !r_div0) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    assign o_busy    = (r_state != S_IDLE);
    assign o_res_vld = (r_state == S_FIX);
    assign o_res_hi  = r_is_div ? w_rem_fix : w_prod[2*WIDTH-1:WIDTH];
    assign o_res_lo  = r_is_div ? w_quo_fix : w_prod[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_is_div <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_cnt    <= CNT_W'(WIDTH);
                    r_acc    <= {{WIDTH{1'b0}}, w_rs_abs};
                    r_opb    <= w_rt_abs;
                    r_neg_q  <= w_rs_neg ^ w_rt_neg;
                    r_neg_r  <= w_rs_neg;
                    r_div0   <= i_is_div && (i_rt == '0);
                    r_is_div <= i_is_div;
`ifdef ALU_MD_DIV_EN
                    r_state  <= i_is_div ? S_DIV : S_MUL;
`else
                    r_state  <= S_MUL;
`endif
                end
                S_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
                end
`ifdef ALU_MD_DIV_EN
                S_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/alu_md_ctrl.sv
// ALU control decode plus HI/LO and a multi-cycle MULT/DIV sequencer (DIV only with ALU_MD_DIV_EN).
// ctrl_command is combinational; HI/LO ops stall while the sequencer runs (WIDTH+1 busy cycles).
module alu_md_ctrl
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       Op_from_control,
    input  logic [5:0]       fonction,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       ctrl_command,
    output logic [1:0]       md_sel,
    output logic             md_stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic             w_rtype, w_mfhi, w_mflo, w_mthi, w_mtlo, w_mul, w_div, w_md_op;
    logic             w_start, w_res_vld;
    logic [3:0]       w_fn_cmd;
    logic [WIDTH-1:0] w_res_hi, w_res_lo;
    logic             r_done;
    logic [WIDTH-1:0] r_hi, r_lo;

    assign w_rtype = (Op_from_control == OP_RTYPE);
    assign w_mfhi  = w_rtype && (fonction == FN_MFHI);
    assign w_mflo  = w_rtype && (fonction == FN_MFLO);
    assign w_mthi  = w_rtype && (fonction == FN_MTHI);
    assign w_mtlo  = w_rtype && (fonction == FN_MTLO);
    assign w_mul   = w_rtype && (fonction == FN_MULT || fonction == FN_MULTU);
`ifdef ALU_MD_DIV_EN
    assign w_div   = w_rtype && (fonction == FN_DIV || fonction == FN_DIVU);
`else
    assign w_div   = 1'b0;
`endif
    assign w_md_op = w_mul || w_div;

    assign md_stall = in_valid && md_busy && (w_md_op || w_mfhi || w_mflo || w_mthi || w_mtlo);
    assign w_start  = in_valid && w_md_op && !md_busy;

    always_comb begin
        w_fn_cmd = CMD_NOP;
        case (fonction)
            FN_ADD, FN_ADDU: w_fn_cmd = CMD_ADD;
            FN_SUB, FN_SUBU: w_fn_cmd = CMD_SUB;
            FN_AND:          w_fn_cmd = CMD_AND;
            FN_OR:           w_fn_cmd = CMD_OR;
            FN_XOR:          w_fn_cmd = CMD_XOR;
            FN_NOR:          w_fn_cmd = CMD_NOR;
            FN_SLT:          w_fn_cmd = CMD_SLT;
            FN_SLTU:         w_fn_cmd = CMD_SLTU;
            default:         w_fn_cmd = CMD_NOP;
        endcase
    end

    always_comb begin
        ctrl_command = CMD_ADD;
        case (Op_from_control)
            OP_SUB:   ctrl_command = CMD_SUB;
            OP_RTYPE: ctrl_command = w_fn_cmd;
            OP_AND:   ctrl_command = CMD_AND;
            OP_OR:    ctrl_command = CMD_OR;
            OP_SLT:   ctrl_command = CMD_SLT;
            OP_XOR:   ctrl_command = CMD_XOR;
            default:  ctrl_command = CMD_ADD;
        endcase
    end

    assign md_sel = w_mfhi ? SEL_HI : (w_mflo ? SEL_LO : SEL_ALU);

    md_iter_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_is_div  (w_div),
        .i_signed  (~fonction[0]),
        .i_rs      (rs_val),
        .i_rt      (rt_val),
        .o_busy    (md_busy),
        .o_res_vld (w_res_vld),
        .o_res_hi  (w_res_hi),
        .o_res_lo  (w_res_lo)
    );

    // MTHI/MTLO cannot collide with a result write: both stall while the sequencer is busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_res_vld;
            if (w_res_vld) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (in_valid && w_mthi && !md_stall) r_hi <= rs_val;
                if (in_valid && w_mtlo && !md_stall) r_lo <= rs_val;
            end
        end
    end

    assign md_done = r_done;
    assign hi      = r_hi;
    assign lo      = r_lo;
endmodule

// File: tb/tb_alu_md_ctrl.sv
// Randomised bench for alu_md_ctrl against an arithmetic reference model of HI/LO and decode.
module tb_alu_md_ctrl;
    import alu_md_pkg::*;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    op;
    logic [5:0]    fn;
    logic          in_valid;
    logic [W-1:0]  rs, rt;
    logic [3:0]    ctrl_command;
    logic [1:0]    md_sel;
    logic          md_stall, md_busy, md_done;
    logic [W-1:0]  hi, lo;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [W-1:0]  m_hi, m_lo;

    alu_md_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .Op_from_control(op), .fonction(fn), .in_valid(in_valid),
        .rs_val(rs), .rt_val(rt), .ctrl_command(ctrl_command), .md_sel(md_sel),
        .md_stall(md_stall), .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_fn(input logic [5:0] f);
        case (f)
            6'h20, 6'h21: return 4'b0010;
            6'h22, 6'h23: return 4'b0110;
            6'h24:        return 4'b0000;
            6'h25:        return 4'b0001;
            6'h26:        return 4'b0011;
            6'h27:        return 4'b1100;
            6'h2A:        return 4'b0111;
            6'h2B:        return 4'b1000;
            default:      return 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] exp_cmd(input logic [3:0] o, input logic [5:0] f);
        case (o)
            4'd1:    return 4'b0110;
            4'd2:    return exp_fn(f);
            4'd3:    return 4'b0000;
            4'd4:    return 4'b0001;
            4'd5:    return 4'b0111;
            4'd6:    return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic [1:0] exp_sel(input logic [3:0] o, input logic [5:0] f);
        if (o == 4'd2 && f == 6'h10) return 2'b01;
        if (o == 4'd2 && f == 6'h12) return 2'b10;
        return 2'b00;
    endfunction

    // Architectural result of an MD op computed with plain 64-bit arithmetic
    task automatic md_model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] h, output logic [W-1:0] l, output bit ok);
        longint sa, sb, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ok = 1'b1;
        h  = m_hi;
        l  = m_lo;
        case (f)
            6'h18: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            6'h19: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
`ifdef ALU_MD_DIV_EN
            6'h1A: if (b == 0) begin h = a; l = '1; end
                   else begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
            6'h1B: if (b == 0) begin h = a; l = '1; end
                   else begin l = a / b; h = a % b; end
`endif
            default: ok = 1'b0;
        endcase
    endtask

    task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        bit ok;
        int nb, nd;
        md_model(f, a, b, eh, el, ok);
        op = OP_RTYPE; fn = f; rs = a; rt = b; in_valid = 1'b1;
        #1 chk("issue_stall", {63'd0, md_stall}, 64'd0);
        tick();
        in_valid = 1'b0;
        nb = 0; nd = 0;
        for (int i = 0; i < W + 8; i++) begin
            if (md_busy) nb++;
            if (md_done) nd++;
            tick();
        end
        chk($sformatf("busy_cycles_fn%0h", f), 64'(nb), ok ? 64'(W + 1) : 64'd0);
        chk($sformatf("done_pulses_fn%0h", f), 64'(nd), ok ? 64'd1 : 64'd0);
        chk($sformatf("hi_fn%0h_%0h_%0h", f, a, b), {32'd0, hi}, {32'd0, eh});
        chk($sformatf("lo_fn%0h_%0h_%0h", f, a, b), {32'd0, lo}, {32'd0, el});
        m_hi = eh; m_lo = el;
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 300));
            1:       return -32'($urandom_range(1, 300));
            2:       return ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] fns [19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                             6'h2B, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h3F};
    logic [5:0] md_fns [4] = '{6'h18, 6'h19, 6'h1A, 6'h1B};

    initial begin
        logic [W-1:0] a, b, c, d, eh, el, h2, l2;
        bit ok, seen;
        int ns, nb, nd;

        rst = 1'b1; in_valid = 1'b0; op = 4'd0; fn = 6'd0; rs = '0; rt = '0;
        m_hi = '0; m_lo = '0;
        tick(); tick();
        rst = 1'b0;
        op = OP_RTYPE; fn = FN_MFHI; in_valid = 1'b1;
        #1;
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, md_busy}, 64'd0);
        chk("rst_done", {63'd0, md_done}, 64'd0);
        chk("rst_stall", {63'd0, md_stall}, 64'd0);
        in_valid = 1'b0;

        // R-type sweep of listed functs, then random op classes
        for (int i = 0; i < 19; i++) begin
            op = 4'd2; fn = fns[i];
            #1;
            chk($sformatf("rtype_cmd_%0h", fns[i]), {60'd0, ctrl_command}, {60'd0, exp_cmd(op, fn)});
            chk($sformatf("rtype_sel_%0h", fns[i]), {62'd0, md_sel}, {62'd0, exp_sel(op, fn)});
        end
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15)); fn = 6'($urandom); in_valid = 1'($urandom);
            #1;
            chk($sformatf("op_cmd_%0h_%0h", op, fn), {60'd0, ctrl_command}, {60'd0, exp_cmd(op, fn)});
            chk($sformatf("op_sel_%0h_%0h", op, fn), {62'd0, md_sel}, {62'd0, exp_sel(op, fn)});
            chk("idle_stall", {63'd0, md_stall}, 64'd0);
        end
        in_valid = 1'b0;
        tick();

        // MTHI / MTLO while idle
        a = $urandom; b = $urandom;
        op = OP_RTYPE; fn = FN_MTHI; rs = a; in_valid = 1'b1; tick();
        fn = FN_MTLO; rs = b; tick();
        in_valid = 1'b0;
        chk("mthi", {32'd0, hi}, {32'd0, a});
        chk("mtlo", {32'd0, lo}, {32'd0, b});
        m_hi = a; m_lo = b;

        run_md(FN_MULT, -32'd3, 32'd7);
        run_md(FN_DIVU, 32'd100, 32'd7);
        run_md(FN_DIV, -32'd7, 32'd2);
        run_md(FN_DIV, 32'd5, 32'd0);
        run_md(FN_DIV, -32'd9, 32'd0);
        run_md(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) run_md(md_fns[$urandom_range(0, 3)], rnd_opnd(), rnd_opnd());

        // MFLO held from cycle 2 of a MULTU; an ADD issued mid-op flows freely
        a = $urandom; b = $urandom;
        md_model(FN_MULTU, a, b, eh, el, ok);
        op = OP_RTYPE; fn = FN_MULTU; rs = a; rt = b; in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        op = OP_ADD; fn = 6'($urandom); in_valid = 1'b1;
        #1;
        chk("add_mid_stall", {63'd0, md_stall}, 64'd0);
        chk("add_mid_cmd", {60'd0, ctrl_command}, 64'h2);
        tick();
        op = OP_RTYPE; fn = FN_MFLO; in_valid = 1'b1;
        ns = 0; seen = 1'b0;
        for (int i = 0; i < W + 8 && !seen; i++) begin
            #1;
            if (md_done) seen = 1'b1;
            else begin
                if (md_stall) ns++;
                tick();
            end
        end
        chk("mflo_saw_done", {63'd0, seen}, 64'd1);
        chk("mflo_stall_cycles", 64'(ns), 64'(W - 1));
        chk("mflo_done_stall", {63'd0, md_stall}, 64'd0);
        chk("mflo_done_sel", {62'd0, md_sel}, 64'd2);
        chk("mflo_done_lo", {32'd0, lo}, {32'd0, el});
        tick();
        in_valid = 1'b0;
        m_hi = eh; m_lo = el;

        // Back-to-back: second op held under stall is taken in the md_done cycle
        a = rnd_opnd(); b = rnd_opnd(); c = $urandom; d = $urandom;
        md_model(FN_MULT, a, b, eh, el, ok);
        md_model(FN_MULTU, c, d, h2, l2, ok);
        op = OP_RTYPE; fn = FN_MULT; rs = a; rt = b; in_valid = 1'b1; tick();
        fn = FN_MULTU; rs = c; rt = d;
        ns = 0; seen = 1'b0;
        for (int i = 0; i < W + 8 && !seen; i++) begin
            #1;
            if (md_done) seen = 1'b1;
            else begin
                if (md_stall) ns++;
                tick();
            end
        end
        chk("b2b_saw_done", {63'd0, seen}, 64'd1);
        chk("b2b_stall_cycles", 64'(ns), 64'(W + 1));
        chk("b2b_done_stall", {63'd0, md_stall}, 64'd0);
        chk("b2b_hi1", {32'd0, hi}, {32'd0, eh});
        chk("b2b_lo1", {32'd0, lo}, {32'd0, el});
        tick();
        in_valid = 1'b0;
        chk("b2b_accept", {63'd0, md_busy}, 64'd1);
        tick();
        nb = 0; nd = 0;
        for (int i = 0; i < W + 6; i++) begin
            if (md_busy) nb++;
            if (md_done) nd++;
            tick();
        end
        chk("b2b_busy2", 64'(nb), 64'(W));
        chk("b2b_done2", 64'(nd), 64'd1);
        chk("b2b_hi2", {32'd0, hi}, {32'd0, h2});
        chk("b2b_lo2", {32'd0, lo}, {32'd0, l2});

        // Reset at cycle 10 of a long op aborts without a done pulse
        op = OP_RTYPE; rs = $urandom; rt = $urandom | 32'd1; in_valid = 1'b1;
`ifdef ALU_MD_DIV_EN
        fn = FN_DIV;
`else
        fn = FN_MULT;
`endif
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("mid_busy", {63'd0, md_busy}, 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstmid_busy", {63'd0, md_busy}, 64'd0);
        chk("rstmid_done", {63'd0, md_done}, 64'd0);
        chk("rstmid_hi", {32'd0, hi}, 64'd0);
        chk("rstmid_lo", {32'd0, lo}, 64'd0);
        nb = 0; nd = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (md_busy) nb++;
            if (md_done) nd++;
            tick();
        end
        chk("rstmid_no_busy", 64'(nb), 64'd0);
        chk("rstmid_no_done", 64'(nd), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
